ctrl_unit: RTL and testbench

- Instruction sequencer directly downstream of the program ROM/PC stage.
- Consumes the 24-bit instruction word the ROM presents combinationally at the current PC.
- Drives the ROM's `enable` (advance) and `jump_enable`/`jump_data` inputs.
- Decodes each instruction into register-file, ALU and data-memory control, and stalls on a memory req/ack handshake.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/ctrl_decode.sv | 111 +++++++++++
 rtl/ctrl_unit.sv | 209 ++++++++++++++++++++
 tb/tb_ctrl_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: field widths, opcodes,
// ALU operation codes, write-back select codes, error codes and FSM states.
package cpu_pkg;

  localparam int CPU_INSTR_W     = 24;
  localparam int CPU_ADDR_W      = 8;
  localparam int CPU_MEM_TIMEOUT = 15;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_JNZ  = 8'h12;
  localparam logic [7:0] OP_LD   = 8'h20;
  localparam logic [7:0] OP_ST   = 8'h21;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder. Maps the latched instruction register
// to register-file, ALU, jump and memory controls.
// Ports:
//   ir          in   latched instruction {opcode, fa, fb}
//   zero_flag   in   registered ALU zero flag (conditional jumps)
//   alu_op      out  ALU operation select
//   reg_we      out  register write for single-cycle ops (LD write-back is
//                    issued by the FSM on the ack cycle)
//   reg_waddr   out  destination register
//   reg_raddr_a out  read port A address
//   reg_raddr_b out  read port B address
//   wb_sel      out  write-back source
//   imm         out  immediate operand
//   is_jump     out  jump is taken (condition already resolved)
//   jump_target out  jump destination
//   is_mem      out  LD or ST
//   mem_we      out  ST
//   mem_addr    out  data-memory address
//   is_halt     out  HALT opcode
//   illegal     out  unrecognised opcode
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [CPU_INSTR_W-1:0] ir,
  input  logic                   zero_flag,
  output logic [2:0]             alu_op,
  output logic                   reg_we,
  output logic [3:0]             reg_waddr,
  output logic [3:0]             reg_raddr_a,
  output logic [3:0]             reg_raddr_b,
  output logic [1:0]             wb_sel,
  output logic [7:0]             imm,
  output logic                   is_jump,
  output logic [CPU_ADDR_W-1:0]  jump_target,
  output logic                   is_mem,
  output logic                   mem_we,
  output logic [CPU_ADDR_W-1:0]  mem_addr,
  output logic                   is_halt,
  output logic                   illegal
);

  logic [7:0] opcode;
  logic [7:0] fa;
  logic [7:0] fb;
  logic       unused_fa_hi;

  assign opcode       = ir[23:16];
  assign fa           = ir[15:8];
  assign fb           = ir[7:0];
  assign unused_fa_hi = ^fa[7:4];
  assign jump_target  = fb;
  assign mem_addr     = fb;

  always_comb begin
    alu_op      = ALU_PASS;
    reg_we      = 1'b0;
    reg_waddr   = 4'd0;
    reg_raddr_a = 4'd0;
    reg_raddr_b = 4'd0;
    wb_sel      = WB_ALU;
    imm         = 8'd0;
    is_jump     = 1'b0;
    is_mem      = 1'b0;
    mem_we      = 1'b0;
    is_halt     = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_LDI: begin
        reg_we    = 1'b1;
        reg_waddr = fa[3:0];
        wb_sel    = WB_IMM;
        imm       = fb;
      end
      OP_MOV: begin
        reg_raddr_a = fb[3:0];
        alu_op      = ALU_PASS;
        reg_we      = 1'b1;
        reg_waddr   = fa[3:0];
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        reg_raddr_a = fa[3:0];
        reg_raddr_b = fb[3:0];
        reg_we      = 1'b1;
        reg_waddr   = fa[3:0];
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_OR;
        endcase
      end
      OP_JMP: is_jump = 1'b1;
      OP_JZ:  is_jump = zero_flag;
      OP_JNZ: is_jump = ~zero_flag;
      OP_LD: begin
        is_mem    = 1'b1;
        reg_waddr = fa[3:0];
        wb_sel    = WB_MEM;
      end
      OP_ST: begin
        is_mem      = 1'b1;
        mem_we      = 1'b1;
        reg_raddr_a = fa[3:0];
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Instruction sequencer sitting after the program ROM/PC stage. Latches the
// ROM word in FETCH, decodes it in EXEC, stalls on the data-memory handshake
// and parks in HALT with sticky halted/error flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr, pc                ROM word and its PC
//   pc_enable                ROM advance strobe (FETCH only)
//   jump_enable, jump_data   ROM PC load (EXEC of a taken jump)
//   zero_flag                registered ALU zero flag
//   alu_op, reg_*, wb_sel, imm  register-file / ALU control
//   mem_req, mem_we, mem_addr, mem_ack  data-memory handshake
//   halted, error            sticky status, cleared only by rst
//
// state      | meaning
// S_FETCH    | latch instr/pc into IR/IR_PC, advance ROM PC
// S_EXEC     | decode IR, issue strobes or jump, pick next state
// S_MEM_WAIT | hold memory request until mem_ack or timeout
// S_HALT     | idle, all strobes low
module ctrl_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W     = CPU_INSTR_W,
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_enable,
  output logic               jump_enable,
  output logic [ADDR_W-1:0]  jump_data,
  input  logic               zero_flag,
  output logic [2:0]         alu_op,
  output logic               reg_we,
  output logic [3:0]         reg_waddr,
  output logic [3:0]         reg_raddr_a,
  output logic [3:0]         reg_raddr_b,
  output logic [1:0]         wb_sel,
  output logic [7:0]         imm,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  output logic               halted,
  output logic [1:0]         error
);

  localparam logic [3:0] TMO_LOAD = 4'(MEM_TIMEOUT - 1);

  state_e             state;
  state_e             state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic [3:0]         tmo_cnt;
  logic               err_set;
  logic [1:0]         err_code;
  logic               at_last_pc;

  logic [2:0]        dec_alu_op;
  logic              dec_reg_we;
  logic [3:0]        dec_waddr;
  logic [3:0]        dec_raddr_a;
  logic [3:0]        dec_raddr_b;
  logic [1:0]        dec_wb_sel;
  logic [7:0]        dec_imm;
  logic              dec_is_jump;
  logic [ADDR_W-1:0] dec_target;
  logic              dec_is_mem;
  logic              dec_mem_we;
  logic [ADDR_W-1:0] dec_mem_addr;
  logic              dec_is_halt;
  logic              dec_illegal;

  ctrl_decode u_decode (
    .ir          (ir),
    .zero_flag   (zero_flag),
    .alu_op      (dec_alu_op),
    .reg_we      (dec_reg_we),
    .reg_waddr   (dec_waddr),
    .reg_raddr_a (dec_raddr_a),
    .reg_raddr_b (dec_raddr_b),
    .wb_sel      (dec_wb_sel),
    .imm         (dec_imm),
    .is_jump     (dec_is_jump),
    .jump_target (dec_target),
    .is_mem      (dec_is_mem),
    .mem_we      (dec_mem_we),
    .mem_addr    (dec_mem_addr),
    .is_halt     (dec_is_halt),
    .illegal     (dec_illegal)
  );

  // The ROM PC saturates, so an instruction at the last address must not
  // fall through to another fetch of itself.
  assign at_last_pc = (ir_pc == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      ir      <= '0;
      ir_pc   <= '0;
      tmo_cnt <= 4'd0;
      halted  <= 1'b0;
      error   <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir    <= instr;
        ir_pc <= pc;
      end
      // Down-counter: terminal count 0 marks the last allowed wait cycle.
      if (state == S_EXEC) begin
        tmo_cnt <= TMO_LOAD;
      end else if (state == S_MEM_WAIT) begin
        tmo_cnt <= tmo_cnt - 4'd1;
      end
      if (state_nxt == S_HALT) begin
        halted <= 1'b1;
      end
      if (err_set && (error == ERR_NONE)) begin
        error <= err_code;
      end
    end
  end

  // Outputs depend only on state, IR, zero_flag, mem_ack and rst; instr
  // reaches nothing but the IR register. rst gates every output so the
  // memory request drops in the same cycle reset is raised.
  always_comb begin
    state_nxt   = state;
    err_set     = 1'b0;
    err_code    = ERR_NONE;
    pc_enable   = 1'b0;
    jump_enable = 1'b0;
    jump_data   = '0;
    alu_op      = ALU_PASS;
    reg_we      = 1'b0;
    reg_waddr   = 4'd0;
    reg_raddr_a = 4'd0;
    reg_raddr_b = 4'd0;
    wb_sel      = WB_ALU;
    imm         = 8'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          pc_enable = 1'b1;
          state_nxt = S_EXEC;
        end
        S_EXEC: begin
          alu_op      = dec_alu_op;
          reg_we      = dec_reg_we;
          reg_waddr   = dec_waddr;
          reg_raddr_a = dec_raddr_a;
          reg_raddr_b = dec_raddr_b;
          wb_sel      = dec_wb_sel;
          imm         = dec_imm;
          jump_enable = dec_is_jump;
          jump_data   = dec_is_jump ? dec_target : '0;
          mem_we      = dec_mem_we;
          mem_addr    = dec_is_mem ? dec_mem_addr : '0;
          if (dec_illegal) begin
            err_set   = 1'b1;
            err_code  = ERR_ILLEGAL;
            state_nxt = S_HALT;
          end else if (dec_is_halt) begin
            state_nxt = S_HALT;
          end else if (dec_is_mem) begin
            state_nxt = S_MEM_WAIT;
          end else if (at_last_pc && !dec_is_jump) begin
            err_set   = 1'b1;
            err_code  = ERR_OVERRUN;
            state_nxt = S_HALT;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_MEM_WAIT: begin
          mem_req     = 1'b1;
          mem_we      = dec_mem_we;
          mem_addr    = dec_mem_addr;
          reg_raddr_a = dec_raddr_a;
          reg_waddr   = dec_waddr;
          wb_sel      = dec_wb_sel;
          if (mem_ack) begin
            reg_we = ~dec_mem_we;
            if (at_last_pc) begin
              err_set   = 1'b1;
              err_code  = ERR_OVERRUN;
              state_nxt = S_HALT;
            end else begin
              state_nxt = S_FETCH;
            end
          end else if (tmo_cnt == 4'd0) begin
            err_set   = 1'b1;
            err_code  = ERR_TIMEOUT;
            state_nxt = S_HALT;
          end
        end
        S_HALT: ;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] instr;
  logic [7:0]  pc;
  logic        pc_enable, jump_enable;
  logic [7:0]  jump_data;
  logic        zero_flag = 1'b0;
  logic [2:0]  alu_op;
  logic        reg_we;
  logic [3:0]  reg_waddr, reg_raddr_a, reg_raddr_b;
  logic [1:0]  wb_sel;
  logic [7:0]  imm;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic        halted;
  logic [1:0]  error;

  int checks = 0;
  int passed = 0;
  int overlap = 0;
  int cnt_a, cnt_b;
  logic [9:0] we_mask;

  logic [23:0] rom [256];

  always #5 clk = ~clk;

  // ROM/PC stage model: load beats advance, advance saturates at 0xFF.
  assign instr = rom[pc];
  always @(posedge clk) begin
    if (rst) pc <= 8'h00;
    else if (jump_enable) pc <= jump_data;
    else if (pc_enable && pc != 8'hFF) pc <= pc + 8'h01;
  end

  always @(negedge clk) if (pc_enable && jump_enable) overlap++;

  ctrl_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .pc_enable(pc_enable), .jump_enable(jump_enable), .jump_data(jump_data),
    .zero_flag(zero_flag), .alu_op(alu_op), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_raddr_a(reg_raddr_a), .reg_raddr_b(reg_raddr_b),
    .wb_sel(wb_sel), .imm(imm), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .halted(halted), .error(error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
  endtask

  // Leaves the bench 1 ns after the edge that starts cycle 0 (first FETCH).
  task automatic reset_dut();
    rst = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] pack(input logic je, input logic [7:0] jd, input logic [2:0] alu,
                                       input logic we, input logic [3:0] wa, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [1:0] wb, input logic [7:0] im,
                                       input logic pe, input logic mr);
    return {je, jd, alu, we, wa, ra, rb, wb, im, pe, mr};
  endfunction

  typedef struct {
    string       name;
    logic [23:0] word;
    logic        zf;
    logic        je;
    logic [7:0]  jd;
    logic [2:0]  alu;
    logic        we;
    logic [3:0]  wa, ra, rb;
    logic [1:0]  wb;
    logic [7:0]  im;
    logic        use_ra, use_rb;
    logic [7:0]  next_pc;
  } vec_t;

  vec_t vecs[12];
  logic [36:0] act_p, exp_p, msk;

  initial begin
    vecs[0]  = '{"ldi",    24'h010105, 0, 0, 8'h00, 3'd0, 1, 4'h1, 4'h0, 4'h0, 2'd1, 8'h05, 0, 0, 8'h01};
    vecs[1]  = '{"mov",    24'h020407, 0, 0, 8'h00, 3'd0, 1, 4'h4, 4'h7, 4'h0, 2'd0, 8'h00, 1, 0, 8'h01};
    vecs[2]  = '{"add",    24'h030102, 0, 0, 8'h00, 3'd1, 1, 4'h1, 4'h1, 4'h2, 2'd0, 8'h00, 1, 1, 8'h01};
    vecs[3]  = '{"sub",    24'h040506, 0, 0, 8'h00, 3'd2, 1, 4'h5, 4'h5, 4'h6, 2'd0, 8'h00, 1, 1, 8'h01};
    vecs[4]  = '{"and",    24'h050309, 0, 0, 8'h00, 3'd3, 1, 4'h3, 4'h3, 4'h9, 2'd0, 8'h00, 1, 1, 8'h01};
    vecs[5]  = '{"or",     24'h060F00, 0, 0, 8'h00, 3'd4, 1, 4'hF, 4'hF, 4'h0, 2'd0, 8'h00, 1, 1, 8'h01};
    vecs[6]  = '{"nop",    24'h000000, 0, 0, 8'h00, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h01};
    vecs[7]  = '{"jmp",    24'h100010, 0, 1, 8'h10, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h10};
    vecs[8]  = '{"jz_nt",  24'h110020, 0, 0, 8'h00, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h01};
    vecs[9]  = '{"jz_t",   24'h110020, 1, 1, 8'h20, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h20};
    vecs[10] = '{"jnz_t",  24'h120033, 0, 1, 8'h33, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h33};
    vecs[11] = '{"jnz_nt", 24'h120033, 1, 0, 8'h00, 3'd0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 8'h01};

    // Outputs while reset is held.
    clear_rom();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {pc_enable, jump_enable, reg_we, mem_req, mem_we, mem_addr, halted, error, alu_op, wb_sel, imm},
          '0);

    // Single-instruction decode table: EXEC outputs, then the next fetch PC.
    for (int v = 0; v < 12; v++) begin
      clear_rom();
      rom[0] = vecs[v].word;
      zero_flag = vecs[v].zf;
      reset_dut();
      @(negedge clk);
      tick();
      @(negedge clk);
      exp_p = pack(vecs[v].je, vecs[v].jd, vecs[v].alu, vecs[v].we, vecs[v].wa, vecs[v].ra,
                   vecs[v].rb, vecs[v].wb, vecs[v].im, 1'b0, 1'b0);
      act_p = pack(jump_enable, jump_data, alu_op, reg_we, reg_waddr, reg_raddr_a,
                   reg_raddr_b, wb_sel, imm, pc_enable, mem_req);
      msk = pack(1'b1, vecs[v].je ? 8'hFF : 8'h00, (vecs[v].we && vecs[v].wb == 2'd0) ? 3'h7 : 3'h0,
                 1'b1, vecs[v].we ? 4'hF : 4'h0, vecs[v].use_ra ? 4'hF : 4'h0,
                 vecs[v].use_rb ? 4'hF : 4'h0, vecs[v].we ? 2'h3 : 2'h0,
                 (vecs[v].we && vecs[v].wb == 2'd1) ? 8'hFF : 8'h00, 1'b1, 1'b1);
      check({vecs[v].name, "_exec"}, 64'(act_p & msk), 64'(exp_p & msk));
      tick();
      @(negedge clk);
      check({vecs[v].name, "_next_fetch"}, {pc_enable, pc}, {1'b1, vecs[v].next_pc});
    end
    zero_flag = 1'b0;

    // Program: LDI r1,5; LDI r2,3; ADD r1,r2; HALT.
    clear_rom();
    rom[0] = 24'h010105; rom[1] = 24'h010203; rom[2] = 24'h030102; rom[3] = 24'hFF0000;
    reset_dut();
    we_mask = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      we_mask[c] = reg_we;
      if (c == 3) check("prog_ldi2", {reg_waddr, wb_sel, imm}, {4'h2, 2'd1, 8'h03});
      if (c == 5) check("prog_add_alu", {alu_op, reg_raddr_a, reg_raddr_b}, {3'd1, 4'h1, 4'h2});
      if (c == 7) check("prog_halted_c7", halted, 1'b0);
      if (c == 8) check("prog_halted_c8", {halted, error}, {1'b1, 2'd0});
      tick();
    end
    check("prog_we_pulses", we_mask, 10'b0000101010);
    check("prog_pc_stop", pc, 8'h04);

    // LD r3,0x40 with a stray ack in EXEC and the real ack in the 4th wait cycle.
    clear_rom();
    rom[0] = 24'h200340;
    reset_dut();
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 9; c++) begin
      mem_ack = (c == 1 || c == 5);
      @(negedge clk);
      if (mem_req) cnt_a++;
      if (mem_req && (mem_addr != 8'h40 || mem_we != 1'b0)) cnt_b++;
      if (c == 5) check("ld_ack_wb", {reg_we, wb_sel, reg_waddr}, {1'b1, 2'd2, 4'h3});
      if (c == 6) check("ld_refetch", {pc_enable, mem_req, pc}, {1'b1, 1'b0, 8'h01});
      tick();
    end
    mem_ack = 1'b0;
    check("ld_req_cycles", cnt_a, 4);
    check("ld_req_stable", cnt_b, 0);

    // ST r5,0x80 acked on the first wait cycle.
    clear_rom();
    rom[0] = 24'h210580;
    reset_dut();
    @(negedge clk); tick(); @(negedge clk); tick();
    mem_ack = 1'b1;
    @(negedge clk);
    check("st_wait", {mem_req, mem_we, mem_addr, reg_raddr_a, reg_we}, {1'b1, 1'b1, 8'h80, 4'h5, 1'b0});
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("st_refetch", {pc_enable, mem_req}, 2'b10);

    // LD with no ack: 15 wait cycles, then timeout halt.
    clear_rom();
    rom[0] = 24'h200340;
    reset_dut();
    cnt_a = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (mem_req) cnt_a++;
      if (c == 16) check("tmo_c16", {halted, error, mem_req}, {1'b0, 2'd0, 1'b1});
      if (c == 17) check("tmo_c17", {halted, error, mem_req}, {1'b1, 2'd2, 1'b0});
      tick();
    end
    check("tmo_req_cycles", cnt_a, 15);

    // Illegal opcode 0x7E.
    clear_rom();
    rom[0] = 24'h7E0000;
    reset_dut();
    cnt_a = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 1 && (jump_enable || reg_we || mem_req || (pc_enable && c >= 1))) cnt_a++;
      if (c == 2) check("illegal_flags", {halted, error}, {1'b1, 2'd1});
      tick();
    end
    check("illegal_no_strobes", cnt_a, 0);
    check("illegal_pc", pc, 8'h01);
    reset_dut();
    @(negedge clk);
    check("sticky_cleared", {halted, error, pc_enable}, {1'b0, 2'd0, 1'b1});

    // NOP at 0xFF reached by a jump.
    clear_rom();
    rom[0] = 24'h1000FF;
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) check("ovr_fetch_pc", {pc_enable, pc}, {1'b1, 8'hFF});
      if (c == 3) check("ovr_c3", {halted, error}, {1'b0, 2'd0});
      if (c == 4) check("ovr_c4", {halted, error, pc_enable}, {1'b1, 2'd3, 1'b0});
      tick();
    end

    // Reset raised during MEM_WAIT.
    clear_rom();
    rom[0] = 24'h200340;
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) check("rst_pre_req", mem_req, 1'b1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_drop", {mem_req, reg_we, pc_enable}, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_refetch", {pc_enable, mem_req, halted, error, pc}, {1'b1, 1'b0, 1'b0, 2'd0, 8'h00});

    check("no_pc_jump_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
